pipeline_ctrl_regs: RTL

PIPELINE_CTRL_REGS -- requirements
Module: pipeline_ctrl_regs

---
 rtl/pipeline_ctrl_regs_if.sv | 81 ++++++++
 rtl/pipeline_ctrl_regs.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_regs_if
// Brief    : Decode-side inputs and D/E/M stage control outputs of the
//            pipeline control register block.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_regs_if;
  logic       w_stall;
  logic       w_flush;
  logic       w_valid;
  logic       w_alu_op;
  logic       w_shift_op;
  logic       w_imm_op;
  logic       w_jump_op;
  logic       w_mem_op;
  logic       w_write_op;
  logic [4:0] w_rs_addr_5;
  logic [4:0] w_rt_addr_5;
  logic [4:0] w_rd_addr_5;

  logic       w_dvalid;
  logic       w_dalu_op;
  logic       w_dimm_op;
  logic       w_dshift_op;
  logic       w_dmem_op;
  logic       w_djump_op;
  logic       w_dwrite_op;
  logic [4:0] w_drs_addr_5;
  logic [4:0] w_drt_addr_5;
  logic [4:0] w_drd_addr_5;

  logic       w_evalid;
  logic       w_ealu_op;
  logic       w_eimm_op;
  logic       w_eshift_op;
  logic       w_emem_op;
  logic       w_ejump_op;
  logic       w_ewrite_op;
  logic [4:0] w_ers_addr_5;
  logic [4:0] w_ert_addr_5;
  logic [4:0] w_erd_addr_5;

  logic       w_mvalid;
  logic       w_malu_op;
  logic       w_mimm_op;
  logic       w_mshift_op;
  logic       w_mmem_op;
  logic       w_mwrite_op;
  logic [4:0] w_wb_regfile_addr_5;
  logic       w_wb_we;

  logic        w_hold_fetch;
  logic [15:0] w_stall_count_16;
  logic [15:0] w_retire_count_16;

  modport master (
    output w_stall, w_flush, w_valid, w_alu_op, w_shift_op, w_imm_op,
           w_jump_op, w_mem_op, w_write_op, w_rs_addr_5, w_rt_addr_5, w_rd_addr_5,
    input  w_dvalid, w_dalu_op, w_dimm_op, w_dshift_op, w_dmem_op, w_djump_op,
           w_dwrite_op, w_drs_addr_5, w_drt_addr_5, w_drd_addr_5,
           w_evalid, w_ealu_op, w_eimm_op, w_eshift_op, w_emem_op, w_ejump_op,
           w_ewrite_op, w_ers_addr_5, w_ert_addr_5, w_erd_addr_5,
           w_mvalid, w_malu_op, w_mimm_op, w_mshift_op, w_mmem_op, w_mwrite_op,
           w_wb_regfile_addr_5, w_wb_we, w_hold_fetch, w_stall_count_16,
           w_retire_count_16
  );

  modport slave (
    input  w_stall, w_flush, w_valid, w_alu_op, w_shift_op, w_imm_op,
           w_jump_op, w_mem_op, w_write_op, w_rs_addr_5, w_rt_addr_5, w_rd_addr_5,
    output w_dvalid, w_dalu_op, w_dimm_op, w_dshift_op, w_dmem_op, w_djump_op,
           w_dwrite_op, w_drs_addr_5, w_drt_addr_5, w_drd_addr_5,
           w_evalid, w_ealu_op, w_eimm_op, w_eshift_op, w_emem_op, w_ejump_op,
           w_ewrite_op, w_ers_addr_5, w_ert_addr_5, w_erd_addr_5,
           w_mvalid, w_malu_op, w_mimm_op, w_mshift_op, w_mmem_op, w_mwrite_op,
           w_wb_regfile_addr_5, w_wb_we, w_hold_fetch, w_stall_count_16,
           w_retire_count_16
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_regs
// Brief    : D/E/M control pipeline registers with stall/flush bubbling,
//            writeback destination select and saturating perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl_regs (
  input  wire logic           clock,
  input  wire logic           reset_n,
  pipeline_ctrl_regs_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic       alu;
    logic       imm;
    logic       shift;
    logic       mem;
    logic       jump;
    logic       write;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } stage_t;

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  stage_t      w_dec;
  stage_t      r_d;
  stage_t      r_e;
  logic        w_bubble;
  logic        w_hold;
  logic [4:0]  w_dest;
  logic        w_wb_we_next;
  logic        r_mvalid;
  logic        r_malu;
  logic        r_mimm;
  logic        r_mshift;
  logic        r_mmem;
  logic        r_mwrite;
  logic [4:0]  r_wb_addr;
  logic        r_wb_we;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_retire_cnt;

  assign w_bubble = bus.w_stall | bus.w_flush | ~bus.w_valid;
  assign w_hold   = bus.w_stall & ~bus.w_flush;

  always_comb begin
    w_dec = '0;
    if (!w_bubble) begin
      w_dec.valid = 1'b1;
      w_dec.alu   = bus.w_alu_op;
      w_dec.imm   = bus.w_imm_op;
      w_dec.shift = bus.w_shift_op;
      w_dec.mem   = bus.w_mem_op;
      w_dec.jump  = bus.w_jump_op;
      w_dec.write = bus.w_write_op;
      w_dec.rs    = bus.w_rs_addr_5;
      w_dec.rt    = bus.w_rt_addr_5;
      w_dec.rd    = bus.w_rd_addr_5;
    end
  end

  // R-type and shifts write rd; immediate ALU ops and loads write rt.
  always_comb begin
    w_dest = 5'd0;
    if (r_e.alu && (!r_e.imm || r_e.shift)) begin
      w_dest = r_e.rd;
    end else if ((r_e.alu && r_e.imm && !r_e.shift) || (r_e.mem && !r_e.write)) begin
      w_dest = r_e.rt;
    end
  end

  assign w_wb_we_next = r_e.valid & (r_e.alu | (r_e.mem & ~r_e.write)) & (w_dest != 5'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_d          <= '0;
      r_e          <= '0;
      r_mvalid     <= 1'b0;
      r_malu       <= 1'b0;
      r_mimm       <= 1'b0;
      r_mshift     <= 1'b0;
      r_mmem       <= 1'b0;
      r_mwrite     <= 1'b0;
      r_wb_addr    <= 5'd0;
      r_wb_we      <= 1'b0;
      r_stall_cnt  <= 16'd0;
      r_retire_cnt <= 16'd0;
    end else begin
      r_d       <= w_dec;
      r_e       <= r_d;
      r_mvalid  <= r_e.valid;
      r_malu    <= r_e.alu;
      r_mimm    <= r_e.imm;
      r_mshift  <= r_e.shift;
      r_mmem    <= r_e.mem;
      r_mwrite  <= r_e.write;
      r_wb_addr <= w_dest;
      r_wb_we   <= w_wb_we_next;
      if (w_hold && (r_stall_cnt != C_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      // Counted as the instruction lands in M, so the count includes the one on display.
      if (r_e.valid && (r_retire_cnt != C_CNT_MAX)) begin
        r_retire_cnt <= r_retire_cnt + 16'd1;
      end
    end
  end

  assign bus.w_dvalid     = r_d.valid;
  assign bus.w_dalu_op    = r_d.alu;
  assign bus.w_dimm_op    = r_d.imm;
  assign bus.w_dshift_op  = r_d.shift;
  assign bus.w_dmem_op    = r_d.mem;
  assign bus.w_djump_op   = r_d.jump;
  assign bus.w_dwrite_op  = r_d.write;
  assign bus.w_drs_addr_5 = r_d.rs;
  assign bus.w_drt_addr_5 = r_d.rt;
  assign bus.w_drd_addr_5 = r_d.rd;

  assign bus.w_evalid     = r_e.valid;
  assign bus.w_ealu_op    = r_e.alu;
  assign bus.w_eimm_op    = r_e.imm;
  assign bus.w_eshift_op  = r_e.shift;
  assign bus.w_emem_op    = r_e.mem;
  assign bus.w_ejump_op   = r_e.jump;
  assign bus.w_ewrite_op  = r_e.write;
  assign bus.w_ers_addr_5 = r_e.rs;
  assign bus.w_ert_addr_5 = r_e.rt;
  assign bus.w_erd_addr_5 = r_e.rd;

  assign bus.w_mvalid            = r_mvalid;
  assign bus.w_malu_op           = r_malu;
  assign bus.w_mimm_op           = r_mimm;
  assign bus.w_mshift_op         = r_mshift;
  assign bus.w_mmem_op           = r_mmem;
  assign bus.w_mwrite_op         = r_mwrite;
  assign bus.w_wb_regfile_addr_5 = r_wb_addr;
  assign bus.w_wb_we             = r_wb_we;

  assign bus.w_hold_fetch      = w_hold;
  assign bus.w_stall_count_16  = r_stall_cnt;
  assign bus.w_retire_count_16 = r_retire_cnt;

endmodule
`default_nettype wire
